hack_data_mem: RTL and testbench
================================

# hack_data_mem

Parametrised Hack data-memory map with a valid/ready request port and a registered response port.
- Routes each access to internal RAM, screen or keyboard storage, in the same address layout as the existing combinational data memory.
- Adds one-cycle registered reads, response backpressure and invalid-address error reporting.
- Adds a latched keyboard register with a clear-on-read option and a screen write-notify port for a display controller.
- Sits between the CPU data port and the I/O devices.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 15, request address width
- RAM_AW, 14, RAM address width; RAM occupies 0 .. 2^RAM_AW-1
- SCR_AW, 13, screen address width; screen occupies 2^RAM_AW .. 2^RAM_AW+2^SCR_AW-1
- KBD_ADDR, 24576, single keyboard address
- KBD_CLR_ON_RD, 0, 1: a keyboard read clears the latch
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1 write, 0 read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  invalid address, or write to keyboard
- kbd_strobe  in  1  one-cycle key event
- kbd_code  in  DATA_W  scan code, sampled on kbd_strobe
- scr_wr_valid  out  1  one-cycle pulse per accepted screen write
- scr_wr_addr  out  SCR_AW  screen-relative address
- scr_wr_data  out  DATA_W  written word

## Operation
- Decode regions:
  - RAM: addr < 2^RAM_AW.
  - SCREEN: 2^RAM_AW ≤ addr < 2^RAM_AW+2^SCR_AW.
  - KBD: addr == KBD_ADDR.
  - INVALID: all other addresses.
- Response buffer: single entry, two states.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - FULL→EMPTY on rsp_ready with no new request.
  - FULL stays FULL when rsp_ready and a request are accepted in the same cycle.
- req_ready = !rsp_valid | rsp_ready, combinational.
- Accepted RAM/SCREEN write:
  - Array updated at the acceptance edge; response rsp_err=0, rsp_data=0.
  - SCREEN writes also pulse scr_wr_* on the following cycle.
- Accepted read: response carries the array word as it was before any same-edge update.
- KBD read:
  - Returns the latch value.
  - With KBD_CLR_ON_RD=1, the latch clears at the acceptance edge.
- KBD write: no state change; rsp_err=1.
- INVALID access: no state change; rsp_err=1, rsp_data=0.
- Keyboard latch:
  - Loads kbd_code on kbd_strobe.
  - If a strobe coincides with a clearing read, the read returns the old value and the latch takes the new code; the strobe wins over the clear.
- Reset values: rsp_valid=0, rsp_data=0, rsp_err=0, keyboard latch=0, scr_wr_valid=0, scr_wr_addr=0, scr_wr_data=0.
- RAM and screen contents are not reset.
- Reset asserted mid-operation discards any pending response; no partial write occurs.

## Timing
- Read latency: response valid on the cycle after acceptance; throughput 1 access/cycle while rsp_ready=1.
- Write latency: array visible to a read accepted on the next cycle; scr_wr_valid asserted exactly one cycle after acceptance, for one cycle.
- Read-after-write to the same address in consecutive accepts returns the new data.
- Backpressure: rsp_valid, rsp_data and rsp_err are held stable while rsp_valid & !rsp_ready.
- req_ready depends on rsp_ready combinationally; no other input→output combinational path.

## Structure
- Package hack_mem_pkg:
  - region_t enum {REG_RAM, REG_SCREEN, REG_KBD, REG_INVALID};
  - default base constants (SCREEN_BASE=16384, KBD_ADDR=24576).
- Sub-module hack_mem_decode: combinational address → region_t plus region-relative offset, parametrised by ADDR_W/RAM_AW/SCR_AW/KBD_ADDR.
- RAM and screen: inferred synchronous-write arrays in the top level. The response register, keyboard latch and notify register also live in the top level.

## Test plan
- Reset, then write 0x1234 to addr 5, read addr 5 → rsp_valid next cycle, rsp_data=0x1234, rsp_err=0.
- Write 0xBEEF to 16384 → scr_wr_valid pulse one cycle later with scr_wr_addr=0, scr_wr_data=0xBEEF; then read 16384 → 0xBEEF.
- kbd_strobe with code 0x0041, then read 24576 → 0x0041; with KBD_CLR_ON_RD=1, a second read → 0x0000; strobe coincident with that read → read 0x0000, following read 0x0041.
- Read 24577 and write 24576 → each rsp_err=1, rsp_data=0, no array/latch change.
- Hold rsp_ready=0 after a read: req_ready=0, response stable 5 cycles; raise rsp_ready with a back-to-back read queued → both responses delivered in order, no loss.
- Assert rst_n low while rsp_valid=1 → rsp_valid=0 immediately; latch=0 after release; RAM word written before reset still reads back.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared types and default address constants for the Hack data-memory map.
package hack_mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_INVALID
    } region_t;

    localparam int unsigned SCREEN_BASE = 16384;
    localparam int unsigned KBD_ADDR    = 24576;

endpackage

// File: rtl/hack_mem_decode.sv
// Combinational address decode: word address -> region plus offsets into RAM and screen.
module hack_mem_decode
    import hack_mem_pkg::*;
#(
    parameter int          ADDR_W   = 15,
    parameter int          RAM_AW   = 14,
    parameter int          SCR_AW   = 13,
    parameter int unsigned KBD_ADDR = hack_mem_pkg::KBD_ADDR
) (
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic [RAM_AW-1:0] ram_off,
    output logic [SCR_AW-1:0] scr_off
);

    localparam int unsigned     RAM_SIZE = 1 << RAM_AW;
    localparam logic [ADDR_W:0] RAM_END  = (ADDR_W+1)'(RAM_SIZE);
    localparam logic [ADDR_W:0] SCR_END  = (ADDR_W+1)'(RAM_SIZE + (1 << SCR_AW));
    localparam logic [ADDR_W:0] KBD_X    = (ADDR_W+1)'(KBD_ADDR);

    logic [ADDR_W:0] addr_x;

    assign addr_x  = {1'b0, addr};
    assign ram_off = addr[RAM_AW-1:0];
    // Screen offset only needs the low SCR_AW bits of (addr - screen base).
    assign scr_off = addr[SCR_AW-1:0] - RAM_END[SCR_AW-1:0];

    always_comb begin
        if (addr_x < RAM_END) begin
            region = REG_RAM;
        end else if (addr_x < SCR_END) begin
            region = REG_SCREEN;
        end else if (addr_x == KBD_X) begin
            region = REG_KBD;
        end else begin
            region = REG_INVALID;
        end
    end

endmodule

// File: rtl/hack_data_mem.sv
// Hack data memory with valid/ready request port, registered response, keyboard
// latch and screen write-notify port.
module hack_data_mem
    import hack_mem_pkg::*;
#(
    parameter int          DATA_W        = 16,
    parameter int          ADDR_W        = 15,
    parameter int          RAM_AW        = 14,
    parameter int          SCR_AW        = 13,
    parameter int unsigned KBD_ADDR      = hack_mem_pkg::KBD_ADDR,
    parameter bit          KBD_CLR_ON_RD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              kbd_strobe,
    input  logic [DATA_W-1:0] kbd_code,
    output logic              scr_wr_valid,
    output logic [SCR_AW-1:0] scr_wr_addr,
    output logic [DATA_W-1:0] scr_wr_data
);

    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int SCR_WORDS = 1 << SCR_AW;

    region_t           region;
    logic [RAM_AW-1:0] ram_off;
    logic [SCR_AW-1:0] scr_off;
    logic              accept;
    logic              wr_en;
    logic              ram_we;
    logic              scr_we;

    logic [DATA_W-1:0] ram_mem [RAM_WORDS];
    logic [DATA_W-1:0] scr_mem [SCR_WORDS];

    logic              rsp_valid_d, rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_d,  rsp_data_q;
    logic              rsp_err_d,   rsp_err_q;
    logic [DATA_W-1:0] kbd_d,       kbd_q;
    logic              scr_wr_valid_d, scr_wr_valid_q;
    logic [SCR_AW-1:0] scr_wr_addr_d,  scr_wr_addr_q;
    logic [DATA_W-1:0] scr_wr_data_d,  scr_wr_data_q;

    hack_mem_decode #(
        .ADDR_W   (ADDR_W),
        .RAM_AW   (RAM_AW),
        .SCR_AW   (SCR_AW),
        .KBD_ADDR (KBD_ADDR)
    ) u_decode (
        .addr    (req_addr),
        .region  (region),
        .ram_off (ram_off),
        .scr_off (scr_off)
    );

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    // Writes are suppressed while reset is held so no partial write can land.
    assign wr_en     = accept && req_we && rst_n;
    assign ram_we    = wr_en && (region == REG_RAM);
    assign scr_we    = wr_en && (region == REG_SCREEN);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        kbd_d          = kbd_q;
        scr_wr_valid_d = 1'b0;
        scr_wr_addr_d  = scr_wr_addr_q;
        scr_wr_data_d  = scr_wr_data_q;

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b0;
            unique case (region)
                REG_RAM: begin
                    if (!req_we) rsp_data_d = ram_mem[ram_off];
                end
                REG_SCREEN: begin
                    if (req_we) begin
                        scr_wr_valid_d = 1'b1;
                        scr_wr_addr_d  = scr_off;
                        scr_wr_data_d  = req_wdata;
                    end else begin
                        rsp_data_d = scr_mem[scr_off];
                    end
                end
                REG_KBD: begin
                    if (req_we) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = kbd_q;
                        if (KBD_CLR_ON_RD) kbd_d = '0;
                    end
                end
                default: rsp_err_d = 1'b1;
            endcase
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        // A new key event overrides a same-cycle clear-on-read.
        if (kbd_strobe) kbd_d = kbd_code;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            kbd_q          <= '0;
            scr_wr_valid_q <= 1'b0;
            scr_wr_addr_q  <= '0;
            scr_wr_data_q  <= '0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            kbd_q          <= kbd_d;
            scr_wr_valid_q <= scr_wr_valid_d;
            scr_wr_addr_q  <= scr_wr_addr_d;
            scr_wr_data_q  <= scr_wr_data_d;
        end
    end

    // NOTE: memory arrays have no reset so they map onto plain RAM macros.
    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_off] <= req_wdata;
        if (scr_we) scr_mem[scr_off] <= req_wdata;
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign scr_wr_valid = scr_wr_valid_q;
    assign scr_wr_addr  = scr_wr_addr_q;
    assign scr_wr_data  = scr_wr_data_q;

endmodule

// File: tb/tb_hack_data_mem.sv
// Bench for hack_data_mem: directed literal checks plus randomized traffic against a
// behavioural memory-map model compared every cycle.
module tb_hack_data_mem;

    localparam bit CLR = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        kbd_strobe = 1'b0;
    logic [15:0] kbd_code = '0;
    logic        scr_wr_valid;
    logic [12:0] scr_wr_addr;
    logic [15:0] scr_wr_data;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    hack_data_mem #(
        .DATA_W        (16),
        .ADDR_W        (15),
        .RAM_AW        (14),
        .SCR_AW        (13),
        .KBD_ADDR      (24576),
        .KBD_CLR_ON_RD (CLR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .kbd_strobe   (kbd_strobe),
        .kbd_code     (kbd_code),
        .scr_wr_valid (scr_wr_valid),
        .scr_wr_addr  (scr_wr_addr),
        .scr_wr_data  (scr_wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory map as a sparse word store keyed by full address.
    logic [15:0] mem_m [int];
    logic        m_valid, m_err, m_known, m_scr_v;
    logic [15:0] m_data, m_kbd, m_scr_d, kbd_next;
    logic [12:0] m_scr_a;
    bit          acc;
    int          a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_known = 1'b1;
            m_kbd = '0; m_scr_v = 1'b0; m_scr_a = '0; m_scr_d = '0;
        end else begin
            acc      = req_valid && (!m_valid || rsp_ready);
            kbd_next = kbd_strobe ? kbd_code : m_kbd;
            m_scr_v  = 1'b0;
            if (acc) begin
                a = int'(req_addr);
                m_valid = 1'b1; m_data = '0; m_err = 1'b0; m_known = 1'b1;
                if (a < 24576) begin
                    if (req_we) begin
                        mem_m[a] = req_wdata;
                        if (a >= 16384) begin
                            m_scr_v = 1'b1;
                            m_scr_a = 13'(a - 16384);
                            m_scr_d = req_wdata;
                        end
                    end else if (mem_m.exists(a)) begin
                        m_data = mem_m[a];
                    end else begin
                        m_known = 1'b0;
                    end
                end else if (a == 24576) begin
                    if (req_we) begin
                        m_err = 1'b1;
                    end else begin
                        m_data = m_kbd;
                        if (CLR && !kbd_strobe) kbd_next = '0;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            m_kbd = kbd_next;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("req_ready", req_ready, !m_valid || rsp_ready);
            check("rsp_valid", rsp_valid, m_valid);
            if (m_valid) begin
                check("rsp_err", rsp_err, m_err);
                if (m_known) check("rsp_data", rsp_data, m_data);
            end
            check("scr_wr_valid", scr_wr_valid, m_scr_v);
            if (m_scr_v) begin
                check("scr_wr_addr", scr_wr_addr, m_scr_a);
                check("scr_wr_data", scr_wr_data, m_scr_d);
            end
        end
    end

    task automatic access(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                          input logic strobe, input logic [15:0] code,
                          output logic [15:0] data, output logic err);
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b1; kbd_strobe = strobe; kbd_code = code;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; kbd_strobe = 1'b0;
        @(negedge clk);
        check("access_rsp_valid", rsp_valid, 1);
        data = rsp_data;
        err  = rsp_err;
    endtask

    task automatic strobe_key(input logic [15:0] code);
        @(negedge clk); #1;
        kbd_strobe = 1'b1; kbd_code = code;
        @(posedge clk); #1;
        kbd_strobe = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic        e;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_scr_valid", scr_wr_valid, 0);
        check("reset_scr_addr", scr_wr_addr, 0);
        check("reset_scr_data", scr_wr_data, 0);
        check("reset_req_ready", req_ready, 1);
        chk_en = 1'b1;

        access(1, 15'd5, 16'h1234, 0, 0, d, e);
        check("wr5_data", d, 16'h0000);
        check("wr5_err", e, 0);
        access(0, 15'd5, 0, 0, 0, d, e);
        check("rd5_data", d, 16'h1234);
        check("rd5_err", e, 0);

        access(1, 15'd16384, 16'hBEEF, 0, 0, d, e);
        check("scr_pulse", scr_wr_valid, 1);
        check("scr_addr", scr_wr_addr, 0);
        check("scr_data", scr_wr_data, 16'hBEEF);
        @(negedge clk);
        check("scr_pulse_end", scr_wr_valid, 0);
        access(0, 15'd16384, 0, 0, 0, d, e);
        check("rd16384", d, 16'hBEEF);

        access(1, 15'd16383, 16'hA5A5, 0, 0, d, e);
        check("wr_ram_top_noscr", scr_wr_valid, 0);
        access(0, 15'd16383, 0, 0, 0, d, e);
        check("rd16383", d, 16'hA5A5);
        access(1, 15'd24575, 16'h5A5A, 0, 0, d, e);
        check("scr_top_addr", scr_wr_addr, 13'd8191);
        access(0, 15'd24575, 0, 0, 0, d, e);
        check("rd24575", d, 16'h5A5A);

        strobe_key(16'h0041);
        access(0, 15'd24576, 0, 0, 0, d, e);
        check("kbd_rd1", d, 16'h0041);
        access(0, 15'd24576, 0, 0, 0, d, e);
        check("kbd_rd_cleared", d, 16'h0000);
        access(0, 15'd24576, 0, 1, 16'h0041, d, e);
        check("kbd_rd_coincident", d, 16'h0000);
        access(0, 15'd24576, 0, 0, 0, d, e);
        check("kbd_rd_after_strobe", d, 16'h0041);

        strobe_key(16'h0077);
        access(1, 15'd24576, 16'h5555, 0, 0, d, e);
        check("kbd_wr_err", e, 1);
        check("kbd_wr_data", d, 0);
        access(0, 15'd24577, 0, 0, 0, d, e);
        check("inv_rd_err", e, 1);
        check("inv_rd_data", d, 0);
        access(1, 15'd32767, 16'hFFFF, 0, 0, d, e);
        check("inv_wr_err", e, 1);
        check("inv_wr_data", d, 0);
        access(0, 15'd24576, 0, 0, 0, d, e);
        check("kbd_unchanged", d, 16'h0077);
        access(0, 15'd5, 0, 0, 0, d, e);
        check("ram_unchanged", d, 16'h1234);

        // Backpressure with a second read queued behind the held response.
        @(negedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'd5;
        @(posedge clk); #1;
        req_addr = 15'd16384;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 16'h1234);
            check("bp_err", rsp_err, 0);
            check("bp_ready", req_ready, 0);
        end
        #1 rsp_ready = 1'b1;
        #1 check("bp_ready_comb", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", rsp_valid, 1);
        check("bp_second_data", rsp_data, 16'hBEEF);

        // Reset while a response is pending.
        strobe_key(16'h0099);
        @(negedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_valid", rsp_valid, 0);
        check("mid_reset_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        access(0, 15'd24576, 0, 0, 0, d, e);
        check("post_reset_kbd", d, 16'h0000);
        access(0, 15'd5, 0, 0, 0, d, e);
        check("post_reset_ram", d, 16'h1234);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = $urandom_range(0, 1) == 1;
            req_wdata = 16'($urandom);
            case ($urandom_range(0, 4))
                0, 1: req_addr = 15'($urandom_range(0, 15));
                2:    req_addr = 15'(16384 + $urandom_range(0, 15));
                3:    req_addr = 15'd24576;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       req_addr = 15'd16383;
                        1:       req_addr = 15'd24575;
                        2:       req_addr = 15'd24577;
                        default: req_addr = 15'd32767;
                    endcase
                end
            endcase
            rsp_ready  = ($urandom_range(0, 3) != 0);
            kbd_strobe = ($urandom_range(0, 9) == 0);
            kbd_code   = 16'($urandom);
        end
        @(negedge clk); #1;
        req_valid = 1'b0; kbd_strobe = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
